fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// instruction step size and the fetch-queue entry layout.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  // Entry field widths; the top casts its PC/instruction into these fields.
  localparam int FQ_PC_WIDTH    = 64;
  localparam int FQ_INSTR_WIDTH = 32;

  localparam logic [FQ_PC_WIDTH-1:0] PC_STEP = FQ_PC_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic [FQ_PC_WIDTH-1:0]    pc;
    logic [FQ_INSTR_WIDTH-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous fetch queue with flush, async active-high reset and
// simultaneous push/pop when full. DEPTH must be a power of two, >= 2.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  fq_entry_t push_data,
  input  logic      pop,
  output fq_entry_t pop_data,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register, RUN/HALTED FSM and fetch queue feeding decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  ADDR_WIDTH  = 12,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  FQ_DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [PC_WIDTH-1:0]    fetch_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                   misalign_err,
`endif
  output logic                   halted
);

  logic [PC_WIDTH-1:0] pc;
  fetch_state_t        state;
  fq_entry_t           wr_entry;
  fq_entry_t           rd_entry;
  logic                fq_full;
  logic                fq_empty;
  logic                do_pop;
  logic                do_push;
  logic                redirect_misaligned;

  assign imem_addr = pc[ADDR_WIDTH-1:0];
  assign fetch_pc  = pc;
  assign out_valid = !fq_empty;
  assign out_instr = INSTR_WIDTH'(rd_entry.instr);
  assign out_pc    = PC_WIDTH'(rd_entry.pc);

  // A redirect voids any pop and blocks enqueue; the flush discards the queue.
  assign do_pop  = out_valid && out_ready && !redirect_valid;
  assign do_push = (state == RUN) && !redirect_valid && !halt && (!fq_full || do_pop);

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = FQ_PC_WIDTH'(pc);
    wr_entry.instr = FQ_INSTR_WIDTH'(imem_instr);
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Sticky until reset; a later aligned redirect resumes fetch but keeps the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && redirect_misaligned) begin
      misalign_err <= 1'b1;
    end
  end
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign redirect_misaligned = 1'b0;
`endif

  // Redirect outranks halt and enqueue; HALTED is left only through a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      state  <= RUN;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      state  <= redirect_misaligned ? HALTED : RUN;
      halted <= redirect_misaligned;
    end else begin
      if (do_push) begin
        pc <= pc + PC_WIDTH'(PC_STEP);
      end
      if (state == RUN && halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (do_push),
    .push_data (wr_entry),
    .pop       (do_pop),
    .pop_data  (rd_entry),
    .empty     (fq_empty),
    .full      (fq_full)
  );

endmodule
